// File: rtl/biriscv_csr_hpm_pkg.sv
// Shared CSR addresses and widths for the hardware performance-monitor bank.
package biriscv_csr_hpm_pkg;

    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_HPMOVF        = 12'h7C0;
    localparam logic [11:0] CSR_HPMOVFEN      = 12'h7C1;

    localparam int HPM_EVSEL_W  = 8;
    localparam int HPM_BASE_IDX = 3;

    // Address of counter slot i within a bank starting at base.
    function automatic logic [11:0] hpm_addr(input logic [11:0] base, input int unsigned i);
        return base + 12'(i);
    endfunction

endpackage

// File: rtl/biriscv_csr_hpm_counter.sv
// One performance counter: event selector, counter register, write/increment
// arbitration and a combinational wrap pulse for the edge on which it wraps.
module biriscv_hpm_counter
    import biriscv_csr_hpm_pkg::*;
#(
    parameter int COUNTER_W  = 64,
    parameter int NUM_EVENTS = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic [NUM_EVENTS-1:0]  event_i,
    input  logic                   inhibit_i,
    input  logic                   sel_we_i,
    input  logic                   lo_we_i,
    input  logic                   hi_we_i,
    input  logic [31:0]            wdata_i,
    output logic [COUNTER_W-1:0]   count_o,
    output logic [HPM_EVSEL_W-1:0] sel_o,
    output logic                   wrap_o
);

    localparam logic [COUNTER_W-1:0] ONE = COUNTER_W'(1);

    logic [COUNTER_W-1:0]   cnt_q, cnt_d;
    logic [HPM_EVSEL_W-1:0] sel_q, sel_d;
    logic                   ev_sel;
    logic                   inc;

    // Selector 0 or out of range never matches, so the counter stays idle.
    always_comb begin
        ev_sel = 1'b0;
        for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
            if (sel_q == HPM_EVSEL_W'(k + 1)) ev_sel = event_i[k];
        end
    end

    assign inc = ev_sel & ~inhibit_i;

    // A CSR write to either half suppresses the whole increment, carry included.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        if (lo_we_i || hi_we_i) begin
            if (lo_we_i) cnt_d[31:0] = wdata_i;
            if (hi_we_i) cnt_d[COUNTER_W-1:32] = wdata_i[COUNTER_W-33:0];
        end else if (inc) begin
            cnt_d  = cnt_q + ONE;
            wrap_o = &cnt_q;
        end
    end

    assign sel_d = sel_we_i ? wdata_i[HPM_EVSEL_W-1:0] : sel_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign count_o = cnt_q;
    assign sel_o   = sel_q;

endmodule

// File: rtl/biriscv_csr_hpm.sv
// HPM CSR bank: address decode, registered read path, sticky overflow status,
// overflow interrupt enable and the registered interrupt request.
module biriscv_csr_hpm
    import biriscv_csr_hpm_pkg::*;
#(
    parameter int NUM_COUNTERS = 4,
    parameter int COUNTER_W    = 64,
    parameter int NUM_EVENTS   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  csr_ren_i,
    input  logic [11:0]           csr_raddr_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_rhit_o,
    input  logic                  csr_wen_i,
    input  logic [11:0]           csr_waddr_i,
    input  logic [31:0]           csr_wdata_i,
    output logic                  ovf_irq_o
);

    localparam int N = NUM_COUNTERS;

    logic [COUNTER_W-1:0]   cnt [N];
    logic [HPM_EVSEL_W-1:0] sel [N];
    logic [N-1:0]           wrap, lo_we, hi_we, sel_we;
    logic [N-1:0]           inhibit_q, ovfen_q, ovf_q, ovf_d, ovf_clr;
    logic                   irq_q;
    logic [31:0]            rd_val, rdata_q;
    logic                   rd_hit, rhit_q;

    always_comb begin
        lo_we  = '0;
        hi_we  = '0;
        sel_we = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lo_we[i]  = csr_wen_i && (csr_waddr_i == hpm_addr(CSR_MHPMCOUNTER3, i));
            hi_we[i]  = csr_wen_i && (csr_waddr_i == hpm_addr(CSR_MHPMCOUNTER3H, i));
            sel_we[i] = csr_wen_i && (csr_waddr_i == hpm_addr(CSR_MHPMEVENT3, i));
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt
        biriscv_hpm_counter #(
            .COUNTER_W (COUNTER_W),
            .NUM_EVENTS(NUM_EVENTS)
        ) u_cnt (
            .clk_i    (clk_i),
            .rst_n    (rst_n),
            .event_i  (event_i),
            .inhibit_i(inhibit_q[g]),
            .sel_we_i (sel_we[g]),
            .lo_we_i  (lo_we[g]),
            .hi_we_i  (hi_we[g]),
            .wdata_i  (csr_wdata_i),
            .count_o  (cnt[g]),
            .sel_o    (sel[g]),
            .wrap_o   (wrap[g])
        );
    end

    // Wrap is OR-ed after the W1C so a coincident wrap keeps the bit set.
    assign ovf_clr = (csr_wen_i && csr_waddr_i == CSR_HPMOVF) ? csr_wdata_i[HPM_BASE_IDX +: N] : '0;
    assign ovf_d   = (ovf_q & ~ovf_clr) | wrap;

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (csr_raddr_i == hpm_addr(CSR_MHPMCOUNTER3, i) ||
                csr_raddr_i == hpm_addr(CSR_HPMCOUNTER3, i)) begin
                rd_hit = 1'b1;
                rd_val = cnt[i][31:0];
            end
            if (csr_raddr_i == hpm_addr(CSR_MHPMCOUNTER3H, i) ||
                csr_raddr_i == hpm_addr(CSR_HPMCOUNTER3H, i)) begin
                rd_hit = 1'b1;
                rd_val = 32'(cnt[i][COUNTER_W-1:32]);
            end
            if (csr_raddr_i == hpm_addr(CSR_MHPMEVENT3, i)) begin
                rd_hit = 1'b1;
                rd_val = 32'(sel[i]);
            end
        end
        case (csr_raddr_i)
            CSR_MCOUNTINHIBIT: begin rd_hit = 1'b1; rd_val = 32'({inhibit_q, 3'b000}); end
            CSR_HPMOVF:        begin rd_hit = 1'b1; rd_val = 32'({ovf_q, 3'b000});     end
            CSR_HPMOVFEN:      begin rd_hit = 1'b1; rd_val = 32'({ovfen_q, 3'b000});   end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            inhibit_q <= '0;
            ovfen_q   <= '0;
            ovf_q     <= '0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
            rhit_q    <= 1'b0;
        end else begin
            if (csr_wen_i && csr_waddr_i == CSR_MCOUNTINHIBIT) inhibit_q <= csr_wdata_i[HPM_BASE_IDX +: N];
            if (csr_wen_i && csr_waddr_i == CSR_HPMOVFEN)      ovfen_q   <= csr_wdata_i[HPM_BASE_IDX +: N];
            ovf_q   <= ovf_d;
            irq_q   <= |(ovf_q & ovfen_q);
            rdata_q <= csr_ren_i ? rd_val : '0;
            rhit_q  <= csr_ren_i & rd_hit;
        end
    end

    assign csr_rdata_o = rdata_q;
    assign csr_rhit_o  = rhit_q;
    assign ovf_irq_o   = irq_q;

endmodule

// File: tb/tb_biriscv_csr_hpm.sv
// Self-checking bench for biriscv_csr_hpm: directed scenarios then random traffic,
// all checked against a behavioural model of the CSR bank.
module tb_biriscv_csr_hpm;

    localparam int NC = 4;
    localparam int W  = 64;
    localparam int NE = 16;
    localparam longint unsigned CMASK = (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << W) - 64'd1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NE-1:0] ev = '0;
    logic          ren = 1'b0;
    logic [11:0]   raddr = '0;
    logic [31:0]   rdata;
    logic          rhit;
    logic          wen = 1'b0;
    logic [11:0]   waddr = '0;
    logic [31:0]   wdata = '0;
    logic          irq;

    always #5 clk = ~clk;

    biriscv_csr_hpm #(
        .NUM_COUNTERS(NC),
        .COUNTER_W   (W),
        .NUM_EVENTS  (NE)
    ) dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .event_i    (ev),
        .csr_ren_i  (ren),
        .csr_raddr_i(raddr),
        .csr_rdata_o(rdata),
        .csr_rhit_o (rhit),
        .csr_wen_i  (wen),
        .csr_waddr_i(waddr),
        .csr_wdata_i(wdata),
        .ovf_irq_o  (irq)
    );

    // Behavioural model: architectural CSR contents held as plain integers.
    longint unsigned m_cnt [NC];
    int unsigned     m_sel [NC];
    logic [31:0]     m_inh, m_ovf, m_en, impl;
    logic            m_irq;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0;
            m_sel[i] = 0;
        end
        m_inh = 0; m_ovf = 0; m_en = 0; m_irq = 0;
        impl = 0;
        for (int i = 0; i < NC; i++) impl[3+i] = 1'b1;
    endfunction

    function automatic logic [32:0] m_read(input logic [11:0] a);
        int unsigned ai = a;
        for (int i = 0; i < NC; i++) begin
            if (ai == 32'hB03 + i || ai == 32'hC03 + i) return {1'b1, m_cnt[i][31:0]};
            if (ai == 32'hB83 + i || ai == 32'hC83 + i) return {1'b1, 32'(m_cnt[i] >> 32)};
            if (ai == 32'h323 + i) return {1'b1, m_sel[i]};
        end
        if (ai == 32'h320) return {1'b1, m_inh};
        if (ai == 32'h7C0) return {1'b1, m_ovf};
        if (ai == 32'h7C1) return {1'b1, m_en};
        return '0;
    endfunction

    function automatic void m_edge(input logic [NE-1:0] e, input logic we, input logic [11:0] wa,
                                   input logic [31:0] wd);
        logic [31:0] wrapset = 0;
        int unsigned ai = wa;
        logic nirq = |(m_ovf & m_en);
        for (int i = 0; i < NC; i++) begin
            if (we && ai == 32'hB03 + i)
                m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF_0000_0000) | 64'(wd);
            else if (we && ai == 32'hB83 + i)
                m_cnt[i] = ((64'(wd) << 32) | (m_cnt[i] & 64'h0000_0000_FFFF_FFFF)) & CMASK;
            else if (m_sel[i] >= 1 && m_sel[i] <= NE && e[m_sel[i]-1] && !m_inh[3+i]) begin
                if (m_cnt[i] == CMASK) begin
                    m_cnt[i] = 0;
                    wrapset[3+i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (we && ai == 32'h323 + i) m_sel[i] = wd & 32'hFF;
        end
        if (we && ai == 32'h320) m_inh = wd & impl;
        if (we && ai == 32'h7C1) m_en = wd & impl;
        if (we && ai == 32'h7C0) m_ovf = m_ovf & ~wd;
        m_ovf = m_ovf | wrapset;
        m_irq = nirq;
    endfunction

    // One clock: drive, let the edge happen, update the model, check outputs.
    task automatic cyc(input logic [NE-1:0] e, input logic we, input logic [11:0] wa,
                       input logic [31:0] wd, input logic re, input logic [11:0] ra);
        logic [32:0] exp_r;
        ev = e; wen = we; waddr = wa; wdata = wd; ren = re; raddr = ra;
        exp_r = re ? m_read(ra) : 33'd0;
        @(posedge clk);
        m_edge(e, we, wa, wd);
        #1;
        check("rhit", rhit, exp_r[32]);
        check("rdata", rdata, exp_r[31:0]);
        check("irq", irq, m_irq);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cyc('0, 1'b1, a, d, 1'b0, '0);
    endtask

    task automatic rd_expect(input string tag, input logic [11:0] a, input logic [31:0] exp);
        cyc('0, 1'b0, '0, '0, 1'b1, a);
        check(tag, rdata, exp);
    endtask

    logic [NE-1:0] ev2;
    logic [31:0]   saved;

    initial begin
        m_reset();
        ev2 = '0;
        ev2[1] = 1'b1;

        // 1: reset state
        #2;
        check("rst_rdata", rdata, 0);
        check("rst_rhit", rhit, 0);
        check("rst_irq", irq, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        rd_expect("t1_b03", 12'hB03, 0);  check("t1_b03_hit", rhit, 1);
        rd_expect("t1_323", 12'h323, 0);  check("t1_323_hit", rhit, 1);
        rd_expect("t1_7c0", 12'h7C0, 0);  check("t1_7c0_hit", rhit, 1);
        rd_expect("t1_fff", 12'hFFF, 0);  check("t1_fff_hit", rhit, 0);
        cyc('0, 1'b0, '0, '0, 1'b0, '0);
        check("t1_ren_low", rhit, 0);

        // 2: counting and inhibit
        wr(12'h323, 32'd2);
        for (int k = 0; k < 10; k++) cyc(ev2, 1'b0, '0, '0, 1'b0, '0);
        rd_expect("t2_count10", 12'hB03, 32'd10);
        wr(12'h320, 32'h8);
        for (int k = 0; k < 5; k++) cyc(ev2, 1'b0, '0, '0, 1'b0, '0);
        rd_expect("t2_inhibited", 12'hB03, 32'd10);
        rd_expect("t2_shadow", 12'hC03, 32'd10);
        rd_expect("t2_inh_rd", 12'h320, 32'h8);
        wr(12'h320, 32'hFFFF_FFFF);
        rd_expect("t2_inh_mask", 12'h320, 32'h78);
        wr(12'h320, 32'h0);

        // 3: carry into high word, then full wrap and interrupt lag
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'h0);
        cyc(ev2, 1'b0, '0, '0, 1'b0, '0);
        rd_expect("t3_lo", 12'hB03, 32'd0);
        rd_expect("t3_hi", 12'hB83, 32'd1);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'h7C1, 32'h8);
        cyc(ev2, 1'b0, '0, '0, 1'b0, '0);
        check("t3_irq_lag", irq, 0);
        rd_expect("t3_ovf", 12'h7C0, 32'h8);
        check("t3_irq_set", irq, 1);
        rd_expect("t3_wrap_lo", 12'hB03, 32'd0);
        rd_expect("t3_wrap_hi", 12'hB83, 32'd0);

        // 4: write beats a same-cycle increment
        cyc(ev2, 1'b1, 12'hB03, 32'h100, 1'b0, '0);
        cyc(ev2, 1'b0, '0, '0, 1'b1, 12'hB03);
        check("t4_write_wins", rdata, 32'h100);

        // 5: W1C coinciding with a wrap, then W1C alone
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        cyc(ev2, 1'b1, 12'h7C0, 32'h8, 1'b0, '0);
        rd_expect("t5_set_wins", 12'h7C0, 32'h8);
        wr(12'h7C0, 32'h8);
        check("t5_irq_still", irq, 1);
        rd_expect("t5_cleared", 12'h7C0, 32'h0);
        check("t5_irq_drop", irq, 0);

        // 6: disabled selectors, then asynchronous reset mid-count
        wr(12'hB03, 32'h55);
        wr(12'h323, 32'd0);
        for (int k = 0; k < 20; k++) cyc('1, 1'b0, '0, '0, 1'b0, '0);
        rd_expect("t6_sel0", 12'hB03, 32'h55);
        wr(12'h323, 32'(NE + 1));
        for (int k = 0; k < 20; k++) cyc('1, 1'b0, '0, '0, 1'b0, '0);
        rd_expect("t6_sel_oor", 12'hB03, 32'h55);
        wr(12'h323, 32'h0000_AB02);
        rd_expect("t6_sel_upper", 12'h323, 32'h2);
        wr(12'h7C1, 32'h8);
        for (int k = 0; k < 3; k++) cyc('1, 1'b0, '0, '0, 1'b1, 12'hB03);
        ev = '1; ren = 1'b1; raddr = 12'hB03;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("t6_rst_rdata", rdata, 0);
        check("t6_rst_irq", irq, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_expect("t6_post_cnt", 12'hB03, 0);
        rd_expect("t6_post_sel", 12'h323, 0);
        rd_expect("t6_post_en", 12'h7C1, 0);

        // random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic          we, re;
            logic [11:0]   wa, ra;
            logic [31:0]   wd;
            logic [NE-1:0] e;
            int unsigned   i, cat;
            e  = NE'($urandom) | NE'($urandom);
            we = ($urandom_range(0, 2) == 0);
            i  = $urandom_range(0, NC - 1);
            cat = $urandom_range(0, 7);
            wd = $urandom;
            case (cat)
                0: begin wa = 12'hB03 + 12'(i); if ($urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 | (wd & 32'hF); end
                1: begin wa = 12'hB83 + 12'(i); if ($urandom_range(0, 1) == 1) wd = 32'hFFFF_FFFF; end
                2: begin wa = 12'h323 + 12'(i); wd = (wd & 32'hFFFF_FF00) | 32'($urandom_range(0, NE + 2)); end
                3: begin wa = 12'h320; wd = wd & $urandom & $urandom; end
                4: wa = 12'h7C0;
                5: wa = 12'h7C1;
                6: wa = 12'hC03 + 12'(i);
                default: wa = 12'(($urandom & 32'hFFF) | 32'h800);
            endcase
            re = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 8))
                0: ra = 12'hB03 + 12'(i);
                1: ra = 12'hB83 + 12'(i);
                2: ra = 12'hC03 + 12'(i);
                3: ra = 12'hC83 + 12'(i);
                4: ra = 12'h323 + 12'(i);
                5: ra = 12'h320;
                6: ra = 12'h7C0;
                7: ra = 12'h7C1;
                default: ra = 12'h323 + 12'(NC);
            endcase
            cyc(e, we, wa, wd, re, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
